// File: rtl/seg_decode_if.sv
// Two-digit signed 7-segment display bus: the encoder drives it, seg_decode observes it.
// All segment and anode lines are active-low.
interface seg_decode_if;
    logic [7:0] D1_seg;
    logic [7:0] D0_seg;
    logic [3:0] D1_a;
    logic [3:0] D0_a;

    modport master (output D1_seg, D0_seg, D1_a, D0_a);
    modport slave  (input  D1_seg, D0_seg, D1_a, D0_a);
endinterface

// File: rtl/seg_decode.sv
// Receive-side decoder for the signed two-digit display: debounces the bus, recovers the
// 4-bit two's-complement value and flags illegal patterns. SEG_DECODE_ERRCNT_EN adds err_cnt.
module seg_decode #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    seg_decode_if.slave bus,
    output logic [3:0]  value,
    output logic        neg,
    output logic        valid,
    output logic        err,
    output logic        blank
`ifdef SEG_DECODE_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {ST_BLANK, ST_SETTLE, ST_LOCKED, ST_FAULT} state_t;

    localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

    state_t      state_q, state_d;
    logic [23:0] in_q;
    logic [23:0] samp;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  value_q, value_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        blank_q, blank_d;
    logic        have_q, have_d;
    logic        change;

    logic [3:0]  mag;
    logic        mag_ok, sgn_pos, sgn_neg, an_on, an_off, legal;
    logic [3:0]  dec_val;

    assign samp   = {bus.D1_a, bus.D0_a, bus.D1_seg, bus.D0_seg};
    // in_q holds the previous sample; the incoming sample is compared against it so the
    // decision lands on the edge that captures the STABLE_CYCLES-th repeat.
    assign change = (samp != in_q);
    assign cnt_d  = change ? 8'd0 : ((cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1);

    always_comb begin
        mag    = 4'd0;
        mag_ok = 1'b1;
        case (in_q[15:8])
            8'hC0:   mag = 4'd0;
            8'hF9:   mag = 4'd1;
            8'hA4:   mag = 4'd2;
            8'hB0:   mag = 4'd3;
            8'h99:   mag = 4'd4;
            8'h92:   mag = 4'd5;
            8'h82:   mag = 4'd6;
            8'hF8:   mag = 4'd7;
            8'h80:   mag = 4'd8;
            default: mag_ok = 1'b0;
        endcase
    end

    assign sgn_pos = (in_q[7:0] == 8'hFF);
    assign sgn_neg = (in_q[7:0] == 8'hDF);
    assign an_on   = (in_q[23:20] == 4'b1110) && (in_q[19:16] == 4'b1110);
    assign an_off  = (in_q[23:20] == 4'b1111) && (in_q[19:16] == 4'b1111);
    // +8 and -0 are never produced by the encoder.
    assign legal   = an_on && mag_ok &&
                     ((sgn_pos && mag != 4'd8) || (sgn_neg && mag != 4'd0));
    assign dec_val = sgn_neg ? (~mag + 4'd1) : mag;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        blank_d = blank_q;
        have_d  = have_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (change) begin
            state_d = ST_SETTLE;
        end else if (state_q == ST_SETTLE && cnt_d == STAB) begin
            if (an_off) begin
                state_d = ST_BLANK;
                blank_d = 1'b1;
                have_d  = 1'b0;
            end else if (legal) begin
                state_d = ST_LOCKED;
                blank_d = 1'b0;
                value_d = dec_val;
                valid_d = !have_q || (dec_val != value_q);
                have_d  = 1'b1;
            end else begin
                state_d = ST_FAULT;
                blank_d = 1'b0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            in_q    <= 24'hFFFFFF;
            cnt_q   <= 8'd0;
            value_q <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            blank_q <= 1'b1;
            have_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= samp;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            blank_q <= blank_d;
            have_q  <= have_d;
        end
    end

    assign value = value_q;
    assign neg   = value_q[3];
    assign valid = valid_q;
    assign err   = err_q;
    assign blank = blank_q;

`ifdef SEG_DECODE_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            err_cnt_q <= 8'd0;
        else if (err_d && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_decode.sv
// Directed bench for seg_decode (STABLE_CYCLES=4): decision timing, signed decode,
// debounce, illegal patterns, blanking and mid-settle reset.
module tb_seg_decode;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] value;
    logic       neg, valid, err, blank;
`ifdef SEG_DECODE_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_coll = 0;
    int v0, e0;

    seg_decode_if bus ();

    seg_decode #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .value (value),
        .neg   (neg),
        .valid (valid),
        .err   (err),
        .blank (blank)
`ifdef SEG_DECODE_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) n_valid++;
            if (err) n_err++;
            if (valid && err) n_coll++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] d1, input logic [7:0] d0,
                       input logic [3:0] a1, input logic [3:0] a0);
        bus.D1_seg = d1;
        bus.D0_seg = d0;
        bus.D1_a   = a1;
        bus.D0_a   = a0;
    endtask

    initial begin
        reset = 1'b1;
        put(8'hFF, 8'hFF, 4'hF, 4'hF);
        tick(3);
        reset = 1'b0;
        chk("rst_value", value, 4'h0);
        chk("rst_neg", neg, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_blank", blank, 1'b1);
        tick(8);
        chk("idle_pulses", n_valid + n_err, 0);
        chk("idle_blank", blank, 1'b1);

        // +3: sampled at edge E, decision at E+4
        put(8'hB0, 8'hFF, 4'hE, 4'hE);
        tick(1);
        tick(3);
        chk("p3_early_valid", valid, 1'b0);
        chk("p3_settle_blank", blank, 1'b1);
        tick(1);
        chk("p3_valid", valid, 1'b1);
        chk("p3_value", value, 4'h3);
        chk("p3_neg", neg, 1'b0);
        chk("p3_blank", blank, 1'b0);
        tick(1);
        chk("p3_pulse_len", valid, 1'b0);

        // -8
        v0 = n_valid;
        put(8'h80, 8'hDF, 4'hE, 4'hE);
        tick(8);
        chk("m8_value", value, 4'h8);
        chk("m8_neg", neg, 1'b1);
        chk("m8_pulses", n_valid - v0, 1);

        // -1
        v0 = n_valid;
        put(8'hF9, 8'hDF, 4'hE, 4'hE);
        tick(8);
        chk("m1_value", value, 4'hF);
        chk("m1_pulses", n_valid - v0, 1);

        // chatter shorter than the window never decides; settle back on -1 (same value)
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < 6; i++) begin
            put(8'hC0, 8'hFF, 4'hE, 4'hE);
            tick(2);
            put(8'hF9, 8'hFF, 4'hE, 4'hE);
            tick(2);
        end
        put(8'hF9, 8'hDF, 4'hE, 4'hE);
        tick(8);
        chk("bounce_pulses", (n_valid - v0) + (n_err - e0), 0);
        chk("bounce_value", value, 4'hF);

        // +8 is illegal
        e0 = n_err;
        v0 = n_valid;
        put(8'h80, 8'hFF, 4'hE, 4'hE);
        tick(8);
        chk("p8_err", n_err - e0, 1);
        chk("p8_value_held", value, 4'hF);
        chk("p8_blank", blank, 1'b0);

        // unknown magnitude glyph
        put(8'h00, 8'hDF, 4'hE, 4'hE);
        tick(8);
        chk("seg00_err", n_err - e0, 2);
        chk("illegal_no_valid", n_valid - v0, 0);
`ifdef SEG_DECODE_ERRCNT_EN
        chk("err_cnt", err_cnt, 8'd2);
`endif

        // one digit lit, the other dark
        put(8'hC0, 8'hFF, 4'hE, 4'hF);
        tick(8);
        chk("anode_mix_err", n_err - e0, 3);

        // hold +5 for 20 cycles: single pulse
        v0 = n_valid;
        put(8'h92, 8'hFF, 4'hE, 4'hE);
        tick(20);
        chk("p5_value", value, 4'h5);
        chk("p5_hold_pulses", n_valid - v0, 1);

        // blank, then the same +5 publishes again
        put(8'hFF, 8'hFF, 4'hF, 4'hF);
        tick(6);
        chk("blank_level", blank, 1'b1);
        put(8'h92, 8'hFF, 4'hE, 4'hE);
        tick(8);
        chk("p5_again_pulses", n_valid - v0, 2);
        chk("p5_again_blank", blank, 1'b0);

        // reset in the middle of settling on +2
        v0 = n_valid;
        e0 = n_err;
        put(8'hA4, 8'hFF, 4'hE, 4'hE);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midrst_value", value, 4'h0);
        chk("midrst_blank", blank, 1'b1);
        chk("midrst_valid", valid, 1'b0);
        put(8'hFF, 8'hFF, 4'hF, 4'hF);
        tick(1);
        reset = 1'b0;
        tick(8);
        chk("midrst_no_pulse", (n_valid - v0) + (n_err - e0), 0);
        chk("midrst_value_after", value, 4'h0);

        chk("valid_err_excl", n_coll, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
